// File: rtl/dip_input_filter.sv
// Stability filter for the deserialized DIP switch word: accepts a value only after it
// has held for STABLE_CYCLES edges, and reports accepted changes via a sticky mask and IRQ.
module dip_input_filter #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 64
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic [WIDTH-1:0] i_DIP16,
  input  logic             i_ACK,
  output logic [WIDTH-1:0] o_DIP_STABLE,
  output logic             o_VALID,
  output logic [WIDTH-1:0] o_CHANGED_MASK,
  output logic             o_IRQ,
  output logic [7:0]       o_EVENT_COUNT
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] cand_r;
  logic [CW-1:0]    cnt_r;

  logic             same_s;
  logic             sat_s;
  logic             commit_s;
  logic [WIDTH-1:0] delta_s;
  logic [WIDTH-1:0] mask_next_s;

  // commit decision and next change mask, all from pre-edge register values
  always_comb begin
    same_s      = (i_DIP16 == cand_r);
    sat_s       = (cnt_r == CNT_MAX);
    commit_s    = same_s && sat_s && (!o_VALID || (cand_r != o_DIP_STABLE));
    delta_s     = cand_r ^ o_DIP_STABLE;
    mask_next_s = o_CHANGED_MASK;
    if (commit_s && o_VALID) begin
      // an ack on the same edge drops the old bits but keeps this update's bits
      if (i_ACK) begin
        mask_next_s = delta_s;
      end else begin
        mask_next_s = o_CHANGED_MASK | delta_s;
      end
    end else if (i_ACK) begin
      mask_next_s = '0;
    end else begin
      mask_next_s = o_CHANGED_MASK;
    end
  end

  // candidate capture and saturating stability counter
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      cand_r <= '0;
      cnt_r  <= '0;
    end else if (!same_s) begin
      cand_r <= i_DIP16;
      cnt_r  <= '0;
    end else if (!sat_s) begin
      cnt_r  <= cnt_r + CW'(1);
    end
  end

  // accepted word, valid flag, change mask and event counter
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      o_DIP_STABLE   <= '0;
      o_VALID        <= 1'b0;
      o_CHANGED_MASK <= '0;
      o_EVENT_COUNT  <= 8'd0;
    end else begin
      o_CHANGED_MASK <= mask_next_s;
      if (commit_s) begin
        o_DIP_STABLE <= cand_r;
        o_VALID      <= 1'b1;
        // the first acceptance after reset is a baseline, not a change event
        if (o_VALID) begin
          o_EVENT_COUNT <= o_EVENT_COUNT + 8'd1;
        end
      end
    end
  end

  assign o_IRQ = |o_CHANGED_MASK;

endmodule
